iq_avg_snapshot_ctrl: RTL and testbench
=======================================

# iq_avg_snapshot_ctrl

Sequencing controller for the IQ-average snapshot RAM: it owns the fabric-side write port (port A) of the 1024 x 32 snapshot BRAM whose port B is mapped to the processor bus. On a software arm followed by a hardware trigger it writes a programmed number of consecutive valid words from address 0 upward, then freezes and raises `done` so software can read the buffer over port B without fabric writes disturbing it.

## Interface

Parameters:
- `ADDR_WIDTH`, 10, BRAM port-A address width; depth = 2^ADDR_WIDTH words
- `DATA_WIDTH`, 32, sample and BRAM word width

Ports:
- `clk`  in  1  sole clock; BRAM port A shares it
- `rst`  in  1  asynchronous, active-high reset
- `arm`  in  1  software arm level from a control register; the rising edge is the event
- `trig`  in  1  capture-start qualifier, sampled only with `din_valid`
- `length`  in  ADDR_WIDTH+1  words to capture; 0 means 2^ADDR_WIDTH; latched on arm
- `din`  in  DATA_WIDTH  sample word
- `din_valid`  in  1  `din` is valid this cycle
- `bram_we`  out  1  port-A write enable
- `bram_en_a`  out  1  port-A enable; equals `bram_we`
- `bram_addr`  out  ADDR_WIDTH  port-A address
- `bram_wr_data`  out  DATA_WIDTH  port-A write data
- `busy`  out  1  high in ARMED or CAPTURE
- `done`  out  1  high in DONE
- `words_written`  out  ADDR_WIDTH+1  words written since the last arm

Clock and reset are fixed: a single clock, `clk`, and an asynchronous, active-high reset, `rst`.

## Operation

- Rising-edge detect: `arm_q` is registered from `arm`; the event is `arm & ~arm_q`. `arm_q` resets to 1, so an arm level that is already high when reset releases does not fire.
- States are IDLE, ARMED, CAPTURE and DONE.
  - IDLE: an arm event latches `length` into `len_r`, clears the word counter and moves to ARMED.
  - ARMED: a cycle with `din_valid & trig` writes that word to address 0 and moves to CAPTURE. If `len_r` = 1 it moves straight to DONE. Valid words without `trig` are discarded.
  - CAPTURE: each `din_valid` cycle writes `din` to the address equal to the current count, then increments the count. When the write brings the count to `len_r` (0 is treated as 2^ADDR_WIDTH), the state goes to DONE. `trig` is ignored in this state.
  - DONE: no writes occur and inputs are discarded. An arm event re-latches `length`, clears the count and `done`, and moves to ARMED.
- An arm event in ARMED or CAPTURE is ignored; the capture in progress completes.
- The counter width is ADDR_WIDTH+1. A full-depth capture ends with `words_written` = 2^ADDR_WIDTH. Addresses never wrap inside a capture.
- `bram_addr` holds the last written address when idle. It is 0 after reset.

## Timing

- Writes are registered. An accepted `din`/`din_valid` at edge N produces `bram_we`, `bram_addr` and `bram_wr_data` valid during cycle N+1, giving 1-cycle latency. Back-to-back valid data gives one write per cycle.
- `words_written` updates in the same cycle as the corresponding `bram_we`.
- `done` rises in the cycle after the last write's `bram_we` cycle, i.e. 2 cycles after the last accepted word. BRAM contents are stable once `done` = 1.
- `busy` rises the cycle after the arm edge is detected, which is 2 cycles after `arm` rises (synchronous input). It falls in the same cycle `done` rises.
- Reset values are all 0: `bram_we`, `bram_en_a`, `bram_addr`, `bram_wr_data`, `busy`, `done` and `words_written`. The state resets to IDLE.
- Reset asserted mid-capture forces the outputs to 0 immediately (asynchronous), so any pending write is dropped. Data already written stays in the BRAM.
- Arm edge coinciding with the final write: the final write completes, the state enters DONE, and the arm is ignored. Software re-arms after seeing `done`.

## Test plan

- Basic capture:
  - Stimulus: reset, `length` = 4, arm pulse, then `din` = 0x10..0x17 with `din_valid` held high and `trig` high on the 0x12 word.
  - Required response: writes 0x12, 0x13, 0x14, 0x15 to addresses 0..3 in consecutive cycles, `done` 2 cycles after 0x15 is accepted, and `words_written` = 4.
- Gapped valid:
  - Stimulus: `length` = 3, trigger on the first word, `din_valid` pattern 1,0,0,1,0,1.
  - Required response: exactly 3 writes to addresses 0, 1, 2, with no `bram_we` during the gaps.
- Full depth:
  - Stimulus: `length` = 0 with continuous valid data.
  - Required response: 1024 writes, last address 0x3FF, `words_written` = 1024, no write to address 0 after the first, and `done` asserted.
- Arm handling:
  - Stimulus: an arm pulse during CAPTURE.
  - Required response: no restart; the capture finishes normally.
  - Stimulus: arm again in DONE with `length` = 2.
  - Required response: `done` clears, and the next trigger writes addresses 0 and 1.
- Reset and edge cases:
  - Stimulus: `rst` asserted mid-capture at count 5.
  - Required response: outputs are 0 during reset, and after release the state is IDLE with no writes until a fresh arm edge.
  - Stimulus: `arm` held high through reset release.
  - Required response: no arm event.
- Length 1:
  - Stimulus: `length` = 1, with trigger and valid data in the same cycle.
  - Required response: a single write at address 0, `busy` falls and `done` rises 2 cycles after acceptance, and `trig` before arming has no effect.

Source files
------------

// File: rtl/iq_avg_snapshot_ctrl.sv
// Fabric-side (port A) write sequencer for the IQ-average snapshot BRAM.
// Arm, wait for a qualified trigger, write a programmed burst from address 0, then freeze.
module iq_avg_snapshot_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  trig,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  bram_we,
    output logic                  bram_en_a,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t              state;
    logic                arm_q;
    logic                arm_evt;
    logic [ADDR_WIDTH:0] len_r;
    logic [ADDR_WIDTH:0] len_eff;
    logic [ADDR_WIDTH:0] count;
    logic [ADDR_WIDTH:0] count_nxt;

    assign arm_evt       = arm & ~arm_q;
    assign bram_en_a     = bram_we;
    assign words_written = count;

    // Zero and anything beyond the buffer both mean a full-depth capture, so addresses never wrap.
    always_comb begin
        len_eff   = len_r;
        count_nxt = count + 1'b1;
        if (len_r == '0 || len_r > DEPTH) begin
            len_eff = DEPTH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            arm_q        <= 1'b1;
            len_r        <= '0;
            count        <= '0;
            bram_we      <= 1'b0;
            bram_addr    <= '0;
            bram_wr_data <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            arm_q   <= arm;
            bram_we <= 1'b0;
            // Status flags decode the state one cycle late so done follows the last write strobe.
            busy    <= (state == S_ARMED) || (state == S_CAPTURE);
            done    <= (state == S_DONE);
            case (state)
                S_IDLE, S_DONE: begin
                    if (arm_evt) begin
                        len_r <= length;
                        count <= '0;
                        state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (din_valid && trig) begin
                        bram_we      <= 1'b1;
                        bram_addr    <= '0;
                        bram_wr_data <= din;
                        count        <= count_nxt;
                        state        <= (count_nxt == len_eff) ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (din_valid) begin
                        bram_we      <= 1'b1;
                        bram_addr    <= count[ADDR_WIDTH-1:0];
                        bram_wr_data <= din;
                        count        <= count_nxt;
                        if (count_nxt == len_eff) begin
                            state <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_avg_snapshot_ctrl.sv
// Directed bench for iq_avg_snapshot_ctrl: expected port-A writes are queued as stimulus is
// driven and popped by a monitor whenever the DUT strobes bram_we.
module tb_iq_avg_snapshot_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic          trig = 1'b0;
    logic [AW:0]   length = '0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          bram_we;
    logic          bram_en_a;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wr_data;
    logic          busy;
    logic          done;
    logic [AW:0]   words_written;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int base;
    logic [DW-1:0]    rnd;
    logic [AW+DW-1:0] mon_got;
    logic [AW+DW-1:0] mon_exp;
    logic [AW+DW-1:0] exp_q[$];

    iq_avg_snapshot_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .trig         (trig),
        .length       (length),
        .din          (din),
        .din_valid    (din_valid),
        .bram_we      (bram_we),
        .bram_en_a    (bram_en_a),
        .bram_addr    (bram_addr),
        .bram_wr_data (bram_wr_data),
        .busy         (busy),
        .done         (done),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic v, input logic t,
                        input logic exp_w, input logic [AW-1:0] a);
        din       = d;
        din_valid = v;
        trig      = t;
        if (exp_w) exp_q.push_back({a, d});
        tick();
    endtask

    task automatic arm_pulse();
        din_valid = 1'b0;
        trig      = 1'b0;
        arm       = 1'b1;
        tick();
        arm = 1'b0;
        tick();
    endtask

    // Scoreboard side: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && bram_we) begin
            wr_cnt++;
            mon_got = {bram_addr, bram_wr_data};
            chk("en_a_on_write", bram_en_a, 1'b1);
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_write observed=%0h expected=none", mon_got);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                chk("write_addr_data", mon_got, mon_exp);
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_we", bram_we, 0);
        chk("rst_en", bram_en_a, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_data", bram_wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_words", words_written, 0);
        rst = 1'b0;
        tick();

        // Basic capture: trigger on 0x12, four words
        base   = wr_cnt;
        length = 11'd4;
        arm_pulse();
        chk("basic_busy_armed", busy, 1);
        send(32'h10, 1, 0, 0, 0);
        send(32'h11, 1, 0, 0, 0);
        send(32'h12, 1, 1, 1, 0);
        send(32'h13, 1, 0, 1, 1);
        send(32'h14, 1, 0, 1, 2);
        send(32'h15, 1, 0, 1, 3);
        chk("basic_words_with_last_we", words_written, 4);
        chk("basic_done_not_yet", done, 0);
        send(32'h16, 1, 0, 0, 0);
        chk("basic_done", done, 1);
        chk("basic_busy_fall", busy, 0);
        send(32'h17, 1, 0, 0, 0);
        din_valid = 1'b0;
        tick();
        chk("basic_nwrites", wr_cnt - base, 4);
        chk("basic_words", words_written, 4);

        // Gapped valid, re-armed from DONE
        base   = wr_cnt;
        length = 11'd3;
        arm_pulse();
        chk("gap_done_cleared", done, 0);
        chk("gap_busy", busy, 1);
        send(32'hA0, 1, 1, 1, 0);
        send(32'hA1, 0, 0, 0, 0);
        send(32'hA2, 0, 1, 0, 0);
        send(32'hA3, 1, 0, 1, 1);
        send(32'hA4, 0, 0, 0, 0);
        send(32'hA5, 1, 0, 1, 2);
        send(32'hA6, 0, 0, 0, 0);
        chk("gap_done", done, 1);
        chk("gap_words", words_written, 3);
        chk("gap_nwrites", wr_cnt - base, 3);

        // Arm during CAPTURE is ignored; length change mid-capture has no effect
        base   = wr_cnt;
        length = 11'd5;
        arm_pulse();
        send(32'hB0, 1, 1, 1, 0);
        arm = 1'b1;
        send(32'hB1, 1, 0, 1, 1);
        arm    = 1'b0;
        length = 11'd2;
        send(32'hB2, 1, 1, 1, 2);
        send(32'hB3, 1, 0, 1, 3);
        send(32'hB4, 1, 0, 1, 4);
        chk("armcap_words", words_written, 5);
        chk("armcap_done_not_yet", done, 0);
        send(32'hB5, 0, 0, 0, 0);
        chk("armcap_done", done, 1);
        chk("armcap_nwrites", wr_cnt - base, 5);

        // Re-arm in DONE with length 2
        base = wr_cnt;
        arm_pulse();
        chk("rearm_done_clear", done, 0);
        chk("rearm_words_clear", words_written, 0);
        send(32'hEE, 1, 0, 0, 0);
        send(32'h61, 1, 1, 1, 0);
        send(32'h62, 1, 1, 1, 1);
        send(32'h63, 0, 0, 0, 0);
        chk("rearm_done", done, 1);
        chk("rearm_words", words_written, 2);
        chk("rearm_addr_hold", bram_addr, 1);
        chk("rearm_nwrites", wr_cnt - base, 2);

        // Reset mid-capture at count 5
        base   = wr_cnt;
        length = 11'd10;
        arm_pulse();
        send(32'hC0, 1, 1, 1, 0);
        for (int i = 1; i < 5; i++) send(32'hC0 + i, 1, 0, 1, i[AW-1:0]);
        chk("rstcap_words5", words_written, 5);
        din       = 32'h55;
        din_valid = 1'b1;
        trig      = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rstcap_we", bram_we, 0);
        chk("rstcap_addr", bram_addr, 0);
        chk("rstcap_data", bram_wr_data, 0);
        chk("rstcap_words", words_written, 0);
        chk("rstcap_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send(32'hD0 + i, 1, 1, 0, 0);
        chk("rstcap_idle_busy", busy, 0);
        chk("rstcap_idle_done", done, 0);
        chk("rstcap_nwrites", wr_cnt - base, 5);

        // Arm held high through reset release
        base = wr_cnt;
        arm  = 1'b1;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send(32'hE0 + i, 1, 1, 0, 0);
        chk("armhold_busy", busy, 0);
        chk("armhold_nwrites", wr_cnt - base, 0);
        arm       = 1'b0;
        din_valid = 1'b0;
        tick();

        // Length 1; trigger before arming has no effect
        base = wr_cnt;
        send(32'hF0, 1, 1, 0, 0);
        send(32'hF1, 1, 1, 0, 0);
        length = 11'd1;
        arm_pulse();
        send(32'hA5A5_5A5A, 1, 1, 1, 0);
        chk("len1_busy", busy, 1);
        chk("len1_done_not_yet", done, 0);
        chk("len1_words", words_written, 1);
        send(32'h0, 0, 0, 0, 0);
        chk("len1_busy_fall", busy, 0);
        chk("len1_done", done, 1);
        send(32'hF2, 1, 1, 0, 0);
        send(32'hF3, 1, 1, 0, 0);
        chk("len1_nwrites", wr_cnt - base, 1);

        // Full depth, random data, a few untriggered words first
        base   = wr_cnt;
        length = 11'd0;
        arm_pulse();
        for (int i = 0; i < 3; i++) begin
            rnd = $urandom;
            send(rnd, 1, 0, 0, 0);
        end
        for (int i = 0; i < 1024; i++) begin
            rnd = $urandom;
            send(rnd, 1'b1, (i == 0), 1'b1, i[AW-1:0]);
            if ($urandom_range(0, 15) == 0) send(32'h0, 0, 1, 0, 0);
        end
        send(32'h0, 0, 0, 0, 0);
        chk("full_done", done, 1);
        chk("full_words", words_written, 1024);
        chk("full_last_addr", bram_addr, 10'h3FF);
        chk("full_nwrites", wr_cnt - base, 1024);
        for (int i = 0; i < 3; i++) send(32'h77, 1, 1, 0, 0);
        chk("full_frozen", wr_cnt - base, 1024);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
